// File: rtl/conv_window_3x3_pkg.sv
// -----------------------------------------------------------------------------
// conv_window_3x3_pkg
// Shared constants for the 3x3 convolution window generator: kernel size,
// default (MNIST) image geometry and the window element packing index.
// No ports (package).
// -----------------------------------------------------------------------------
package conv_window_3x3_pkg;

    localparam int KERNEL_SZ = 3;
    localparam int WIN_ELEMS = KERNEL_SZ * KERNEL_SZ;

    // Default MNIST geometry.
    localparam int MNIST_W = 28;
    localparam int MNIST_H = 28;

    // Flat element index of window element (r,c); r=0 is the oldest row,
    // c=0 the leftmost column.
    function automatic int win_idx(input int r, input int c);
        return KERNEL_SZ * r + c;
    endfunction

endpackage

// File: rtl/conv_window_3x3_if.sv
// -----------------------------------------------------------------------------
// conv_window_3x3_if
// Pixel-in / window-out bundle of the 3x3 window generator.
//   din_vld, din                       : raster pixel stream (master -> slave)
//   win_vld, win, win_row, win_col,
//   frame_done                         : window stream      (slave -> master)
// Modports: master (stream source / window sink), slave (the window block).
// -----------------------------------------------------------------------------
interface conv_window_3x3_if
    import conv_window_3x3_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 5
);

    logic                          din_vld;
    logic [DATA_W-1:0]             din;
    logic                          win_vld;
    logic [WIN_ELEMS*DATA_W-1:0]   win;
    logic [CNT_W-1:0]              win_row;
    logic [CNT_W-1:0]              win_col;
    logic                          frame_done;

    modport master (
        output din_vld, din,
        input  win_vld, win, win_row, win_col, frame_done
    );

    modport slave (
        input  din_vld, din,
        output win_vld, win, win_row, win_col, frame_done
    );

endinterface

// File: rtl/conv_window_3x3_line_buf_fifo.sv
// -----------------------------------------------------------------------------
// line_buf_fifo
// One image row of delay, built as a circular RAM. On every enabled cycle the
// slot under the pointer is read (dout) and then overwritten with din, so dout
// is the pixel written DEPTH enables earlier.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset (pointer only)
//   en   : advance / write strobe
//   din  : pixel to store
//   dout : combinational read of the oldest stored pixel
// -----------------------------------------------------------------------------
module line_buf_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 28
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  ptr;

    assign dout = mem[ptr];

    // NOTE: nonblocking assignments in clocked blocks so every flop samples
    // the pre-edge values of its neighbours, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
        end
    end

    // NOTE: the storage array is deliberately left out of reset; its contents
    // are never observed before being rewritten, and a resettable array would
    // prevent mapping onto RAM.
    always_ff @(posedge clk) begin
        if (en && !rst) begin
            mem[ptr] <= din;
        end
    end

endmodule

// File: rtl/conv_window_3x3.sv
// -----------------------------------------------------------------------------
// conv_window_3x3
// Turns a raster pixel stream into every fully-inside 3x3 window, with the
// window centre position and an end-of-frame pulse. Two line buffers hold the
// previous two rows; a 3x3 register array shifts one column per pixel.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : conv_window_3x3_if.slave
//         din_vld/din in; win_vld/win/win_row/win_col/frame_done out
// Output timing: window for the pixel accepted at edge k is valid after k.
// -----------------------------------------------------------------------------
module conv_window_3x3
    import conv_window_3x3_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int IMG_W  = MNIST_W,
    parameter int IMG_H  = MNIST_H,
    parameter int CNT_W  = 5
) (
    input  logic               clk,
    input  logic               rst,
    conv_window_3x3_if.slave   bus
);

    logic [DATA_W-1:0] lb0_out;
    logic [DATA_W-1:0] lb1_out;
    logic [DATA_W-1:0] new_col [KERNEL_SZ];
    logic [DATA_W-1:0] win_q   [KERNEL_SZ][KERNEL_SZ];

    logic [CNT_W-1:0]  col_cnt;
    logic [CNT_W-1:0]  row_cnt;
    logic              last_col;
    logic              last_row;
    logic              emit;

    logic              win_vld_q;
    logic              frame_done_q;
    logic [CNT_W-1:0]  win_row_q;
    logic [CNT_W-1:0]  win_col_q;
    logic [WIN_ELEMS*DATA_W-1:0] win_flat;

    // Row delay chain: lb0 gives the row above, lb1 the row above that.
    line_buf_fifo #(.DATA_W(DATA_W), .DEPTH(IMG_W)) u_lb0 (
        .clk  (clk),
        .rst  (rst),
        .en   (bus.din_vld),
        .din  (bus.din),
        .dout (lb0_out)
    );

    line_buf_fifo #(.DATA_W(DATA_W), .DEPTH(IMG_W)) u_lb1 (
        .clk  (clk),
        .rst  (rst),
        .en   (bus.din_vld),
        .din  (lb0_out),
        .dout (lb1_out)
    );

    assign new_col[0] = lb1_out;
    assign new_col[1] = lb0_out;
    assign new_col[2] = bus.din;

    assign last_col = (col_cnt == CNT_W'(IMG_W - 1));
    assign last_row = (row_cnt == CNT_W'(IMG_H - 1));

    // Only windows whose three columns all lie in the current row and whose
    // rows are all of the current frame; this also hides stale line-buffer
    // data at frame start and the mixed-row columns at a row wrap.
    assign emit = bus.din_vld && (row_cnt >= CNT_W'(2)) && (col_cnt >= CNT_W'(2));

    always_ff @(posedge clk) begin
        if (rst) begin
            col_cnt <= '0;
            row_cnt <= '0;
        end else if (bus.din_vld) begin
            if (last_col) begin
                col_cnt <= '0;
                row_cnt <= last_row ? '0 : row_cnt + 1'b1;
            end else begin
                col_cnt <= col_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < KERNEL_SZ; r++) begin
                for (int c = 0; c < KERNEL_SZ; c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else if (bus.din_vld) begin
            for (int r = 0; r < KERNEL_SZ; r++) begin
                for (int c = 0; c < KERNEL_SZ - 1; c++) begin
                    win_q[r][c] <= win_q[r][c+1];
                end
                win_q[r][KERNEL_SZ-1] <= new_col[r];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            win_vld_q    <= 1'b0;
            frame_done_q <= 1'b0;
            win_row_q    <= '0;
            win_col_q    <= '0;
        end else begin
            win_vld_q    <= emit;
            frame_done_q <= emit && last_row && last_col;
            if (emit) begin
                // Centre of the window ending at (row_cnt, col_cnt).
                win_row_q <= row_cnt - 1'b1;
                win_col_q <= col_cnt - 1'b1;
            end
        end
    end

    // NOTE: combinational blocks assign a default first so no path leaves a
    // bit unassigned, which would otherwise infer a latch.
    always_comb begin
        win_flat = '0;
        for (int r = 0; r < KERNEL_SZ; r++) begin
            for (int c = 0; c < KERNEL_SZ; c++) begin
                win_flat[DATA_W*win_idx(r, c) +: DATA_W] = win_q[r][c];
            end
        end
    end

    assign bus.win_vld    = win_vld_q;
    assign bus.frame_done = frame_done_q;
    assign bus.win_row    = win_row_q;
    assign bus.win_col    = win_col_q;
    assign bus.win        = win_flat;

endmodule

// File: tb/tb_conv_window_3x3.sv
// -----------------------------------------------------------------------------
// tb_conv_window_3x3
// Three instances: 4x4 (id 0), 28x28 (id 1) and 3x3 (id 2). Stimulus pushes the
// expected window of each producing pixel into a per-instance queue; monitors
// on the falling edge pop and compare whenever win_vld is seen.
// -----------------------------------------------------------------------------
module tb_conv_window_3x3;
    import conv_window_3x3_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    conv_window_3x3_if #(.DATA_W(8), .CNT_W(5)) if4  ();
    conv_window_3x3_if #(.DATA_W(8), .CNT_W(5)) if28 ();
    conv_window_3x3_if #(.DATA_W(8), .CNT_W(5)) if3  ();

    conv_window_3x3 #(.DATA_W(8), .IMG_W(4),  .IMG_H(4),  .CNT_W(5)) dut4  (.clk(clk), .rst(rst), .bus(if4));
    conv_window_3x3 #(.DATA_W(8), .IMG_W(28), .IMG_H(28), .CNT_W(5)) dut28 (.clk(clk), .rst(rst), .bus(if28));
    conv_window_3x3 #(.DATA_W(8), .IMG_W(3),  .IMG_H(3),  .CNT_W(5)) dut3  (.clk(clk), .rst(rst), .bus(if3));

    typedef struct {
        logic [71:0] win;
        int          row;
        int          col;
        bit          fd;
        int          cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int checks   = 0;
    int failures = 0;
    int nwin [3] = '{0, 0, 0};
    int nfd  [3] = '{0, 0, 0};
    int mr   [3] = '{0, 0, 0};
    int mc   [3] = '{0, 0, 0};
    int img_w[3] = '{4, 28, 3};
    int img_h[3] = '{4, 28, 3};
    logic [7:0] img [3][28][28];
    bit use_model = 1'b0;

    // Hand-computed 4x4 windows for pixel values 0..15 (element 0 in the LSB).
    int          t_pix[4] = '{10, 11, 14, 15};
    logic [71:0] t_win[4] = '{72'h0a_09_08_06_05_04_02_01_00,
                              72'h0b_0a_09_07_06_05_03_02_01,
                              72'h0e_0d_0c_0a_09_08_06_05_04,
                              72'h0f_0e_0d_0b_0a_09_07_06_05};
    int          t_row[4] = '{1, 1, 2, 2};
    int          t_col[4] = '{1, 2, 1, 2};

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int id, input exp_t e);
        case (id)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    function automatic int qsize(input int id);
        case (id)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic exp_t pop(input int id);
        case (id)
            0:       return q0.pop_front();
            1:       return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    task automatic drive(input int id, input bit v, input logic [7:0] d);
        case (id)
            0:       begin if4.din_vld  = v; if4.din  = d; end
            1:       begin if28.din_vld = v; if28.din = d; end
            default: begin if3.din_vld  = v; if3.din  = d; end
        endcase
    endtask

    // Reference frame store: expected window read from absolute coordinates.
    task automatic model(input int id, input logic [7:0] d);
        int   r = mr[id];
        int   c = mc[id];
        exp_t e;
        img[id][r][c] = d;
        if (use_model && r >= 2 && c >= 2) begin
            e.win = '0;
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    e.win[8*(3*i+j) +: 8] = img[id][r-2+i][c-2+j];
            e.row = r - 1;
            e.col = c - 1;
            e.fd  = (r == img_h[id] - 1) && (c == img_w[id] - 1);
            e.cyc = cyc + 1;
            push(id, e);
        end
        if (c == img_w[id] - 1) begin
            c = 0;
            r = (r == img_h[id] - 1) ? 0 : r + 1;
        end else begin
            c++;
        end
        mr[id] = r;
        mc[id] = c;
    endtask

    task automatic send(input int id, input bit v, input logic [7:0] d);
        @(posedge clk);
        #1;
        drive(id, v, d);
        if (v) model(id, d);
    endtask

    // Called right after send() of pixel p; offset adds a constant to every
    // element (second frame of the back-to-back test).
    task automatic push_table(input int p, input int offset);
        exp_t e;
        for (int k = 0; k < 4; k++) begin
            if (p == t_pix[k] + offset) begin
                e.win = t_win[k] + {9{8'(offset)}};
                e.row = t_row[k];
                e.col = t_col[k];
                e.fd  = (k == 3);
                e.cyc = cyc + 1;
                push(0, e);
            end
        end
    endtask

    task automatic drain(input int id);
        repeat (3) send(id, 1'b0, 8'h00);
    endtask

    task automatic mon(input int id, input logic v, input logic [71:0] w,
                       input logic [4:0] r, input logic [4:0] c, input logic fd);
        exp_t e;
        if (v) begin
            nwin[id]++;
            if (fd) nfd[id]++;
            if (qsize(id) == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_win[%0d]: got win_vld=1 row=%0d col=%0d, required no window (cycle %0d)",
                         id, r, c, cyc);
            end else begin
                e = pop(id);
                check($sformatf("win[%0d]", id),        w,   e.win);
                check($sformatf("win_row[%0d]", id),    r,   e.row);
                check($sformatf("win_col[%0d]", id),    c,   e.col);
                check($sformatf("frame_done[%0d]", id), fd,  e.fd);
                check($sformatf("latency[%0d]", id),    cyc, e.cyc);
            end
        end else begin
            check("frame_done_idle", fd, 1'b0);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            mon(0, if4.win_vld,  if4.win,  if4.win_row,  if4.win_col,  if4.frame_done);
            mon(1, if28.win_vld, if28.win, if28.win_row, if28.win_col, if28.frame_done);
            mon(2, if3.win_vld,  if3.win,  if3.win_row,  if3.win_col,  if3.frame_done);
        end
    end

    task automatic end_test(input string name, input int id, input int exp_win, input int exp_fd);
        check({name, "_queue_left"}, qsize(id), 0);
        check({name, "_windows"},    nwin[id],  exp_win);
        check({name, "_frame_done"}, nfd[id],   exp_fd);
        nwin[id] = 0;
        nfd[id]  = 0;
    endtask

    initial begin
        rst = 1'b1;
        for (int id = 0; id < 3; id++) drive(id, 1'b0, 8'h00);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_win_vld",    if4.win_vld,    1'b0);
        check("rst_win",        if4.win,        72'h0);
        check("rst_win_row",    if4.win_row,    5'd0);
        check("rst_win_col",    if4.win_col,    5'd0);
        check("rst_frame_done", if4.frame_done, 1'b0);
        check("rst_win_28",     if28.win,       72'h0);
        check("rst_win_vld_3",  if3.win_vld,    1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // 4x4, continuous stream, hand-computed windows.
        use_model = 1'b0;
        for (int p = 0; p < 16; p++) begin
            send(0, 1'b1, 8'(p));
            push_table(p, 0);
        end
        drain(0);
        end_test("t1", 0, 4, 1);

        // 4x4 with random idle cycles.
        use_model = 1'b1;
        for (int p = 0; p < 16; p++) begin
            if ($urandom_range(0, 1) == 1) send(0, 1'b0, 8'h00);
            send(0, 1'b1, 8'(p));
        end
        drain(0);
        end_test("t2", 0, 4, 1);

        // Two back-to-back 4x4 frames.
        use_model = 1'b0;
        for (int p = 0; p < 16; p++) begin
            send(0, 1'b1, 8'(p));
            push_table(p, 0);
        end
        for (int p = 100; p < 116; p++) begin
            send(0, 1'b1, 8'(p));
            push_table(p, 100);
        end
        drain(0);
        end_test("t3", 0, 8, 2);

        // Reset after pixel 9, with a pixel offered during reset (dropped).
        use_model = 1'b1;
        for (int p = 0; p < 10; p++) send(0, 1'b1, 8'(p));
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive(0, 1'b1, 8'hee);
        mr[0] = 0;
        mc[0] = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(0, 1'b0, 8'h00);
        for (int p = 0; p < 16; p++) send(0, 1'b1, 8'(p));
        drain(0);
        end_test("t4", 0, 4, 1);

        // Full 28x28 frame.
        use_model = 1'b1;
        for (int r = 0; r < 28; r++)
            for (int c = 0; c < 28; c++)
                send(1, 1'b1, 8'((r * 28 + c) % 256));
        drain(1);
        end_test("t5", 1, 676, 1);

        // 3x3 boundary: single window {0..8}.
        use_model = 1'b0;
        for (int p = 0; p < 9; p++) begin
            exp_t e;
            send(2, 1'b1, 8'(p));
            if (p == 8) begin
                e.win = 72'h08_07_06_05_04_03_02_01_00;
                e.row = 1;
                e.col = 1;
                e.fd  = 1'b1;
                e.cyc = cyc + 1;
                push(2, e);
            end
        end
        drain(2);
        end_test("t6", 2, 1, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
